// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared load-type codes and register/link constants for the pipeline.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [2:0] LOAD_W  = 3'd0;
    localparam logic [2:0] LOAD_H  = 3'd1;
    localparam logic [2:0] LOAD_HU = 3'd2;
    localparam logic [2:0] LOAD_B  = 3'd3;
    localparam logic [2:0] LOAD_BU = 3'd4;

    // Return address written by jal/jalr is next_pc plus this offset.
    localparam int unsigned LINK_OFFSET = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// ============================================================================
// Module  : load_extract
// Brief   : Little-endian byte/half/word lane select with sign/zero extension.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_extract
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [1:0]            i_offset,
    input  logic [2:0]            i_load_type,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[8*i_offset +: 8];
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        case (i_load_type)
            LOAD_H:  o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            LOAD_HU: o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            LOAD_B:  o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            LOAD_BU: o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            default: o_data = i_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module  : mem_wb_stage
// Brief   : MEM/WB pipeline latch, write-back mux, committed-result register
//           and saturating retired-instruction counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_valid,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_reg_write,
    input  logic                      i_mem_to_reg,
    input  logic                      i_link,
    input  logic [2:0]                i_load_type,
    input  logic [1:0]                i_byte_offset,
    input  logic [DATA_WIDTH-1:0]     i_alu_result,
    input  logic [DATA_WIDTH-1:0]     i_mem_data,
    input  logic [DATA_WIDTH-1:0]     i_next_pc,
    input  logic [REG_ADDR_WIDTH-1:0] i_write_register,
    output logic                      o_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] o_write_register,
    output logic [DATA_WIDTH-1:0]     o_write_data,
    output logic [DATA_WIDTH-1:0]     o_result,
    output logic [31:0]               o_retired_count
);

    logic                      r_valid;
    logic                      r_reg_write;
    logic                      r_mem_to_reg;
    logic                      r_link;
    logic [2:0]                r_load_type;
    logic [1:0]                r_byte_offset;
    logic [DATA_WIDTH-1:0]     r_alu_result;
    logic [DATA_WIDTH-1:0]     r_mem_data;
    logic [DATA_WIDTH-1:0]     r_next_pc;
    logic [REG_ADDR_WIDTH-1:0] r_write_register;
    logic [DATA_WIDTH-1:0]     r_result;
    logic [31:0]               r_retired_count;

    logic [DATA_WIDTH-1:0]     w_load_data;
    logic [DATA_WIDTH-1:0]     w_write_data;
    logic                      w_reg_write;
    logic                      w_capture;

    // Flush takes priority over stall: a held instruction is dropped on flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid          <= 1'b0;
            r_reg_write      <= 1'b0;
            r_mem_to_reg     <= 1'b0;
            r_link           <= 1'b0;
            r_load_type      <= '0;
            r_byte_offset    <= '0;
            r_alu_result     <= '0;
            r_mem_data       <= '0;
            r_next_pc        <= '0;
            r_write_register <= '0;
        end else if (i_flush) begin
            r_valid          <= 1'b0;
            r_reg_write      <= 1'b0;
            r_mem_to_reg     <= 1'b0;
            r_link           <= 1'b0;
            r_load_type      <= '0;
            r_byte_offset    <= '0;
            r_alu_result     <= '0;
            r_mem_data       <= '0;
            r_next_pc        <= '0;
            r_write_register <= '0;
        end else if (!i_stall) begin
            r_valid          <= i_valid;
            r_reg_write      <= i_reg_write;
            r_mem_to_reg     <= i_mem_to_reg;
            r_link           <= i_link;
            r_load_type      <= i_load_type;
            r_byte_offset    <= i_byte_offset;
            r_alu_result     <= i_alu_result;
            r_mem_data       <= i_mem_data;
            r_next_pc        <= i_next_pc;
            r_write_register <= i_write_register;
        end
    end

    load_extract #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extract (
        .i_word      (r_mem_data),
        .i_offset    (r_byte_offset),
        .i_load_type (r_load_type),
        .o_data      (w_load_data)
    );

    always_comb begin
        if (r_link) begin
            w_write_data = r_next_pc + DATA_WIDTH'(LINK_OFFSET);
        end else if (r_mem_to_reg) begin
            w_write_data = w_load_data;
        end else begin
            w_write_data = r_alu_result;
        end
        w_reg_write = r_valid && r_reg_write
                      && (r_write_register != REG_ADDR_WIDTH'(REG_ZERO));
        w_capture   = i_valid && !i_stall && !i_flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
        end else if (w_reg_write) begin
            r_result <= w_write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired_count <= '0;
        end else if (w_capture && (r_retired_count != 32'hFFFF_FFFF)) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    assign o_reg_write      = w_reg_write;
    assign o_write_register = r_write_register;
    assign o_write_data     = w_write_data;
    assign o_result         = r_result;
    assign o_retired_count  = r_retired_count;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module  : tb_mem_wb_stage
// Brief   : Directed self-checking bench for the MEM/WB stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_stall, i_flush, i_reg_write, i_mem_to_reg, i_link;
    logic [2:0]  i_load_type;
    logic [1:0]  i_byte_offset;
    logic [31:0] i_alu_result, i_mem_data, i_next_pc;
    logic [4:0]  i_write_register;
    logic        o_reg_write;
    logic [4:0]  o_write_register;
    logic [31:0] o_write_data, o_result, o_retired_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_count;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_valid          (i_valid),
        .i_stall          (i_stall),
        .i_flush          (i_flush),
        .i_reg_write      (i_reg_write),
        .i_mem_to_reg     (i_mem_to_reg),
        .i_link           (i_link),
        .i_load_type      (i_load_type),
        .i_byte_offset    (i_byte_offset),
        .i_alu_result     (i_alu_result),
        .i_mem_data       (i_mem_data),
        .i_next_pc        (i_next_pc),
        .i_write_register (i_write_register),
        .o_reg_write      (o_reg_write),
        .o_write_register (o_write_register),
        .o_write_data     (o_write_data),
        .o_result         (o_result),
        .o_retired_count  (o_retired_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic lnk,
                         input logic [2:0] lt, input logic [1:0] off, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] npc, input logic [4:0] rd);
        i_valid = v; i_reg_write = rw; i_mem_to_reg = m2r; i_link = lnk;
        i_load_type = lt; i_byte_offset = off; i_alu_result = alu;
        i_mem_data = mem; i_next_pc = npc; i_write_register = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, LOAD_W, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic do_load(input logic [2:0] lt, input logic [1:0] off,
                           input logic [31:0] exp, input string tag);
        drive(1'b1, 1'b1, 1'b1, 1'b0, lt, off, 32'h5555_5555, 32'h80FF_7F01, 32'h0, 5'd7);
        step();
        exp_count++;
        check(tag, o_write_data, exp);
    endtask

    initial begin
        reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        bubble();
        exp_count = 32'd0;
        step(); step();
        reset = 1'b0;
        check("rst_regwrite", {31'd0, o_reg_write}, 32'd0);
        check("rst_count", o_retired_count, 32'd0);

        // Valid load in the latch, then asynchronous reset mid-cycle
        drive(1'b1, 1'b1, 1'b1, 1'b0, LOAD_W, 2'd0, 32'h0, 32'hAAAA_5555, 32'h0, 5'd3);
        step();
        check("pre_rst_regwrite", {31'd0, o_reg_write}, 32'd1);
        bubble();
        #2 reset = 1'b1;
        #1;
        check("async_rst_regwrite", {31'd0, o_reg_write}, 32'd0);
        check("async_rst_addr", {27'd0, o_write_register}, 32'd0);
        check("async_rst_data", o_write_data, 32'd0);
        check("async_rst_result", o_result, 32'd0);
        check("async_rst_count", o_retired_count, 32'd0);
        #1 reset = 1'b0;

        // First ALU instruction after reset
        drive(1'b1, 1'b1, 1'b0, 1'b0, LOAD_W, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd5);
        step();
        exp_count++;
        check("alu_regwrite", {31'd0, o_reg_write}, 32'd1);
        check("alu_addr", {27'd0, o_write_register}, 32'd5);
        check("alu_data", o_write_data, 32'h0000_1234);
        check("alu_result_lag", o_result, 32'd0);
        bubble();
        step();
        check("alu_result", o_result, 32'h0000_1234);
        check("alu_count", o_retired_count, exp_count);

        // Load extraction
        do_load(LOAD_B,  2'd2, 32'hFFFF_FFFF, "lb_off2");
        do_load(LOAD_BU, 2'd3, 32'h0000_0080, "lbu_off3");
        do_load(LOAD_H,  2'd0, 32'h0000_7F01, "lh_off0");
        do_load(LOAD_H,  2'd2, 32'hFFFF_80FF, "lh_off2");
        do_load(LOAD_HU, 2'd3, 32'h0000_80FF, "lhu_off3");
        do_load(LOAD_W,  2'd1, 32'h80FF_7F01, "lw");
        do_load(3'd7,    2'd3, 32'h80FF_7F01, "unused_code");

        // Link priority over mem_to_reg
        drive(1'b1, 1'b1, 1'b1, 1'b1, LOAD_B, 2'd0, 32'h1, 32'hFFFF_FFFF, 32'h0000_0010, 5'd31);
        step();
        exp_count++;
        check("link_data", o_write_data, 32'h0000_0014);
        check("link_addr", {27'd0, o_write_register}, 32'd31);
        drive(1'b1, 1'b1, 1'b1, 1'b1, LOAD_B, 2'd0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 5'd31);
        step();
        exp_count++;
        check("link_wrap", o_write_data, 32'h0000_0000);

        // Writes to $0 are suppressed but still retire
        drive(1'b1, 1'b1, 1'b0, 1'b0, LOAD_W, 2'd0, 32'h0000_CAFE, 32'h0, 32'h0, 5'd9);
        step();
        exp_count++;
        drive(1'b1, 1'b1, 1'b0, 1'b0, LOAD_W, 2'd0, 32'h0000_DEAD, 32'h0, 32'h0, 5'd0);
        step();
        exp_count++;
        check("r0_regwrite", {31'd0, o_reg_write}, 32'd0);
        check("r0_result_pre", o_result, 32'h0000_CAFE);
        bubble();
        step();
        check("r0_result_hold", o_result, 32'h0000_CAFE);
        check("r0_count", o_retired_count, exp_count);

        // Stall holds the second instruction for two cycles
        drive(1'b1, 1'b1, 1'b0, 1'b0, LOAD_W, 2'd0, 32'h0000_000A, 32'h0, 32'h0, 5'd10);
        step();
        exp_count++;
        check("st_a_data", o_write_data, 32'h0000_000A);
        drive(1'b1, 1'b1, 1'b0, 1'b0, LOAD_W, 2'd0, 32'h0000_000B, 32'h0, 32'h0, 5'd11);
        step();
        exp_count++;
        check("st_b_data", o_write_data, 32'h0000_000B);
        drive(1'b1, 1'b1, 1'b0, 1'b0, LOAD_W, 2'd0, 32'h0000_000C, 32'h0, 32'h0, 5'd12);
        i_stall = 1'b1;
        step();
        check("st_hold1_addr", {27'd0, o_write_register}, 32'd11);
        check("st_hold1_data", o_write_data, 32'h0000_000B);
        step();
        check("st_hold2_data", o_write_data, 32'h0000_000B);
        check("st_hold_count", o_retired_count, exp_count);
        i_stall = 1'b0;
        step();
        exp_count++;
        check("st_c_addr", {27'd0, o_write_register}, 32'd12);
        check("st_c_data", o_write_data, 32'h0000_000C);
        check("st_count", o_retired_count, exp_count);

        // Simultaneous stall and flush gives a bubble
        drive(1'b1, 1'b1, 1'b0, 1'b0, LOAD_W, 2'd0, 32'h0000_000D, 32'h0, 32'h0, 5'd13);
        i_stall = 1'b1; i_flush = 1'b1;
        step();
        check("sf_regwrite", {31'd0, o_reg_write}, 32'd0);
        check("sf_count", o_retired_count, exp_count);
        i_stall = 1'b0; i_flush = 1'b0;
        bubble();
        step();
        check("sf_result", o_result, 32'h0000_000C);

        // Saturation: preload the counter just below max
        force dut.r_retired_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_retired_count;
        #1;
        check("sat_preload", o_retired_count, 32'hFFFF_FFFE);
        drive(1'b1, 1'b1, 1'b0, 1'b0, LOAD_W, 2'd0, 32'h1, 32'h0, 32'h0, 5'd1);
        step();
        check("sat_max", o_retired_count, 32'hFFFF_FFFF);
        step();
        check("sat_hold1", o_retired_count, 32'hFFFF_FFFF);
        step();
        check("sat_hold2", o_retired_count, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
